rf_write_buffer: RTL and testbench
==================================

# rf_write_buffer

Write-side front end for the 32×32 three-port register file. Accepts register write requests over a valid/ready handshake, queues them in a small FIFO and drains one entry per clock onto the file's RW/PW/LE write port. An optional bypass network forwards still-queued data onto the three read ports, so operand fetch never sees stale values.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- wr_valid  in  1  write request present
- wr_ready  out  1  buffer can accept (= count < DEPTH)
- wr_addr  in  ADDR_W  destination register
- wr_data  in  DATA_W  write data
- wb_hold  in  1  inhibits draining this cycle (another writer owns the port)
- RW  out  ADDR_W  to register file write address
- PW  out  DATA_W  to register file write data
- LE  out  1  to register file load enable
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- rd_addr_a/b/c  in  ADDR_W  read addresses (same values driven to RA/RB/RC)
- rd_data_a/b/c  in  DATA_W  register file PA/PB/PC
- fwd_a/b/c  out  DATA_W  operand values to consumers

## Operation
- Push: on posedge with wr_valid && wr_ready; {wr_addr, wr_data} written at tail, tail increments mod DEPTH.
- wr_addr == 0: handshake completes (accepted) but nothing is stored; R0 is hardwired zero.
- Head presentation, combinational from registered state: LE = !empty && !wb_hold; RW/PW = head entry when !empty, else 0.
- Pop: on posedge with LE == 1; head increments mod DEPTH. The register file captures the same entry on the same edge.
- Push and pop on the same edge: both occur; count unchanged.
- Push when full: not possible (wr_ready = 0); no combinational ready-from-pop path.
- FIFO order preserved; duplicate addresses are written in order, so the last write wins.
- Reset (any time, including mid-drain): count = 0, head = tail = 0, LE = 0, RW = 0, PW = 0, wr_ready = 1, empty = 1; queued entries are discarded.

## Timing
- Request accepted at edge N → LE = 1 during cycle N+1 (when it is the head and wb_hold = 0) → written into the file at edge N+1 → visible on PA/PB/PC after edge N+1.
- Throughput: one write per cycle when wb_hold = 0.
- wb_hold asserted: head frozen, LE = 0, pushes continue until full.
- count/empty/wr_ready are registered-state derived and stable all cycle.

## Configuration
- RF_WRITE_BUFFER_BYPASS_EN defined: for each read port x, if rd_addr_x != 0 and any valid entry (including the head being written this cycle) matches rd_addr_x, fwd_x = data of the youngest matching entry. Otherwise fwd_x = rd_data_x. The logic is purely combinational with zero added latency. An entry accepted on the current edge is not forwarded until it is registered.
- Not defined: fwd_x = rd_data_x unconditionally; no comparators are built. Consumers must wait until empty before reading recently written registers.

## Test plan
- Reset, then push (3, 0x14) with wb_hold = 0 → next cycle LE = 1, RW = 3, PW = 0x14; after that edge empty = 1, and the register file reads 0x14 at R3.
- wb_hold = 1, push 4 writes (R1..R4 = 0xA1..0xA4) → wr_ready = 0, count = 4, LE = 0; release the hold → LE high 4 consecutive cycles in order R1..R4, then empty.
- Push (0, 0xFFFF_FFFF) → accepted, count stays 0, LE never asserts.
- With the bypass macro, wb_hold = 1: push (7, 0x11) then (7, 0x22), rd_addr_a = 7, rd_data_a = 0 → fwd_a = 0x22. With rd_addr_b = 0 → fwd_b = rd_data_b. Without the macro → fwd_a = 0.
- Full buffer with wb_hold = 1, wrap pointers by draining 2 entries and pushing 2 more, then assert Reset mid-drain → LE = 0, count = 0, wr_ready = 1 asynchronously; no further writes reach the file.
- Simultaneous push and pop at count = 2 → count stays 2, order intact across the pointer wrap.

Source files
------------

// File: rtl/rf_write_buffer.sv
// Register-file write buffer: queues writes and drains one per cycle onto RW/PW/LE.
// Define RF_WRITE_BUFFER_BYPASS_EN to forward queued data onto the three read ports.
module rf_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wb_hold,
    output logic [ADDR_W-1:0]          RW,
    output logic [DATA_W-1:0]          PW,
    output logic                       LE,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    input  logic [ADDR_W-1:0]          rd_addr_a,
    input  logic [ADDR_W-1:0]          rd_addr_b,
    input  logic [ADDR_W-1:0]          rd_addr_c,
    input  logic [DATA_W-1:0]          rd_data_a,
    input  logic [DATA_W-1:0]          rd_data_b,
    input  logic [DATA_W-1:0]          rd_data_c,
    output logic [DATA_W-1:0]          fwd_a,
    output logic [DATA_W-1:0]          fwd_b,
    output logic [DATA_W-1:0]          fwd_c
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign wr_ready = (count_q < CNT_W'(DEPTH));

    // R0 is hardwired zero: the handshake completes but nothing is queued.
    assign push = wr_valid && wr_ready && (wr_addr != '0);
    assign pop  = LE;

    assign LE = !empty && !wb_hold;
    assign RW = empty ? '0 : addr_mem[head];
    assign PW = empty ? '0 : data_mem[head];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge Clk) begin
        if (push) begin
            addr_mem[tail] <= wr_addr;
            data_mem[tail] <= wr_data;
        end
    end

`ifdef RF_WRITE_BUFFER_BYPASS_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    function automatic logic [DATA_W-1:0] bypass(input logic [ADDR_W-1:0] ra,
                                                 input logic [DATA_W-1:0] rd);
        logic [DATA_W-1:0] v;
        logic [PTR_W-1:0]  idx;
        v = rd;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((ra != '0) && (CNT_W'(k) < count_q) && (addr_mem[idx] == ra))
                v = data_mem[idx];
        end
        return v;
    endfunction

    assign fwd_a = bypass(rd_addr_a, rd_data_a);
    assign fwd_b = bypass(rd_addr_b, rd_data_b);
    assign fwd_c = bypass(rd_addr_c, rd_data_c);
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr_a, rd_addr_b, rd_addr_c};

    assign fwd_a = rd_data_a;
    assign fwd_b = rd_data_b;
    assign fwd_c = rd_data_c;
`endif

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed bench for rf_write_buffer with a behavioural register file on RW/PW/LE.
module tb_rf_write_buffer;

    logic        Clk;
    logic        Reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wb_hold;
    logic [4:0]  RW;
    logic [31:0] PW;
    logic        LE;
    logic [2:0]  count;
    logic        empty;
    logic [4:0]  rd_addr_a, rd_addr_b, rd_addr_c;
    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic [31:0] fwd_a, fwd_b, fwd_c;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rf [32];
    logic [31:0] exp_v;

    rf_write_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_hold(wb_hold), .RW(RW), .PW(PW), .LE(LE), .count(count), .empty(empty),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) if (LE) rf[RW] <= PW;

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        n_checks++; if (LE !== 1'b0)     begin n_fail++; $display("FAIL reset_le: got %b want 0", LE); end
        n_checks++; if (RW !== 5'd0 || PW !== 32'd0) begin n_fail++; $display("FAIL reset_head: got RW=%0d PW=%h want 0/0", RW, PW); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_single();
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h14;
        @(negedge Clk);
        wr_valid = 1'b0;
        n_checks++; if (LE !== 1'b1 || RW !== 5'd3 || PW !== 32'h14)
            begin n_fail++; $display("FAIL single_head: got LE=%b RW=%0d PW=%h want 1/3/14", LE, RW, PW); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
        @(negedge Clk);
        n_checks++; if (empty !== 1'b1 || LE !== 1'b0) begin n_fail++; $display("FAIL single_drained: got empty=%b LE=%b want 1/0", empty, LE); end
        n_checks++; if (rf[3] !== 32'h14) begin n_fail++; $display("FAIL single_rf3: got %h want 14", rf[3]); end
    endtask

    task automatic test_hold();
        wb_hold = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = 5'(i + 1); wr_data = 32'hA1 + 32'(i);
            @(negedge Clk);
        end
        n_checks++; if (wr_ready !== 1'b0 || count !== 3'd4 || LE !== 1'b0)
            begin n_fail++; $display("FAIL hold_full: got ready=%b count=%0d LE=%b want 0/4/0", wr_ready, count, LE); end
        wr_addr = 5'd5; wr_data = 32'hA5;
        @(negedge Clk);
        wr_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL hold_nopush: got count=%0d want 4", count); end
        wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (LE !== 1'b1 || RW !== 5'(i + 1) || PW !== 32'hA1 + 32'(i))
                begin n_fail++; $display("FAIL hold_drain%0d: got LE=%b RW=%0d PW=%h want 1/%0d/%h", i, LE, RW, PW, i + 1, 32'hA1 + 32'(i)); end
            @(negedge Clk);
        end
        n_checks++; if (empty !== 1'b1 || LE !== 1'b0) begin n_fail++; $display("FAIL hold_empty: got empty=%b LE=%b want 1/0", empty, LE); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rf[i + 1] !== 32'hA1 + 32'(i))
                begin n_fail++; $display("FAIL hold_rf%0d: got %h want %h", i + 1, rf[i + 1], 32'hA1 + 32'(i)); end
        end
        n_checks++; if (rf[5] !== 32'd0) begin n_fail++; $display("FAIL hold_rf5: got %h want 0", rf[5]); end
    endtask

    task automatic test_r0();
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", wr_ready); end
        @(negedge Clk);
        wr_valid = 1'b0;
        n_checks++; if (count !== 3'd0 || LE !== 1'b0) begin n_fail++; $display("FAIL r0_drop: got count=%0d LE=%b want 0/0", count, LE); end
        @(negedge Clk);
        n_checks++; if (LE !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL r0_idle: got LE=%b empty=%b want 0/1", LE, empty); end
    endtask

    task automatic test_bypass();
        wb_hold = 1'b1;
        rd_addr_a = 5'd7; rd_data_a = 32'd0;
        rd_addr_b = 5'd0; rd_data_b = 32'h5555;
        rd_addr_c = 5'd9; rd_data_c = 32'h99;
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        @(negedge Clk);
`ifdef RF_WRITE_BUFFER_BYPASS_EN
        exp_v = 32'h11;
`else
        exp_v = 32'd0;
`endif
        n_checks++; if (fwd_a !== exp_v) begin n_fail++; $display("FAIL byp_first: got %h want %h", fwd_a, exp_v); end
        wr_data = 32'h22;
        @(negedge Clk);
        wr_valid = 1'b0;
`ifdef RF_WRITE_BUFFER_BYPASS_EN
        exp_v = 32'h22;
`else
        exp_v = 32'd0;
`endif
        #1;
        n_checks++; if (fwd_a !== exp_v) begin n_fail++; $display("FAIL byp_youngest: got %h want %h", fwd_a, exp_v); end
        n_checks++; if (fwd_b !== 32'h5555) begin n_fail++; $display("FAIL byp_r0: got %h want 5555", fwd_b); end
        n_checks++; if (fwd_c !== 32'h99) begin n_fail++; $display("FAIL byp_nomatch: got %h want 99", fwd_c); end
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL byp_count: got %0d want 2", count); end
        wb_hold = 1'b0;
        #1;
        n_checks++; if (fwd_a !== exp_v || RW !== 5'd7 || PW !== 32'h11)
            begin n_fail++; $display("FAIL byp_drain0: got fwd=%h PW=%h want %h/11", fwd_a, PW, exp_v); end
        @(negedge Clk);
        n_checks++; if (fwd_a !== exp_v || PW !== 32'h22)
            begin n_fail++; $display("FAIL byp_head: got fwd=%h PW=%h want %h/22", fwd_a, PW, exp_v); end
        @(negedge Clk);
        n_checks++; if (fwd_a !== 32'd0 || empty !== 1'b1)
            begin n_fail++; $display("FAIL byp_empty: got fwd=%h empty=%b want 0/1", fwd_a, empty); end
        n_checks++; if (rf[7] !== 32'h22) begin n_fail++; $display("FAIL byp_rf7: got %h want 22", rf[7]); end
    endtask

    task automatic test_wrap_reset();
        wb_hold = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = 5'(10 + i); wr_data = 32'hB0 + 32'(i);
            @(negedge Clk);
        end
        wr_valid = 1'b0;
        wb_hold = 1'b0;
        #1;
        n_checks++; if (RW !== 5'd10) begin n_fail++; $display("FAIL wrap_pop0: got RW=%0d want 10", RW); end
        @(negedge Clk);
        n_checks++; if (RW !== 5'd11) begin n_fail++; $display("FAIL wrap_pop1: got RW=%0d want 11", RW); end
        @(negedge Clk);
        wb_hold = 1'b1; wr_valid = 1'b1;
        wr_addr = 5'd14; wr_data = 32'hB4;
        @(negedge Clk);
        wr_addr = 5'd15; wr_data = 32'hB5;
        @(negedge Clk);
        wr_valid = 1'b0;
        n_checks++; if (count !== 3'd4 || wr_ready !== 1'b0 || RW !== 5'd12)
            begin n_fail++; $display("FAIL wrap_full: got count=%0d ready=%b RW=%0d want 4/0/12", count, wr_ready, RW); end
        wb_hold = 1'b0;
        #2 Reset = 1'b1;
        #1;
        n_checks++; if (LE !== 1'b0 || count !== 3'd0 || wr_ready !== 1'b1 || empty !== 1'b1)
            begin n_fail++; $display("FAIL async_reset: got LE=%b count=%0d ready=%b empty=%b want 0/0/1/1", LE, count, wr_ready, empty); end
        n_checks++; if (RW !== 5'd0 || PW !== 32'd0) begin n_fail++; $display("FAIL async_reset_head: got RW=%0d PW=%h want 0/0", RW, PW); end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++; if (LE !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL post_reset: got LE=%b empty=%b want 0/1", LE, empty); end
        n_checks++; if (rf[10] !== 32'hB0 || rf[11] !== 32'hB1) begin n_fail++; $display("FAIL wrap_rf: got %h %h want b0 b1", rf[10], rf[11]); end
        n_checks++; if (rf[12] !== 32'd0 || rf[13] !== 32'd0 || rf[14] !== 32'd0 || rf[15] !== 32'd0)
            begin n_fail++; $display("FAIL reset_discard: got %h %h %h %h want 0", rf[12], rf[13], rf[14], rf[15]); end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1; wr_addr = 5'd19; wr_data = 32'hBF;
        @(negedge Clk);
        wr_valid = 1'b0;
        @(negedge Clk);
        wb_hold = 1'b1; wr_valid = 1'b1;
        wr_addr = 5'd20; wr_data = 32'hC0;
        @(negedge Clk);
        wr_addr = 5'd21; wr_data = 32'hC1;
        @(negedge Clk);
        wb_hold = 1'b0; wr_addr = 5'd22; wr_data = 32'hC2;
        #1;
        n_checks++; if (LE !== 1'b1 || RW !== 5'd20) begin n_fail++; $display("FAIL b2b_head0: got LE=%b RW=%0d want 1/20", LE, RW); end
        @(negedge Clk);
        n_checks++; if (count !== 3'd2 || RW !== 5'd21) begin n_fail++; $display("FAIL b2b_1: got count=%0d RW=%0d want 2/21", count, RW); end
        wr_addr = 5'd23; wr_data = 32'hC3;
        @(negedge Clk);
        wr_valid = 1'b0;
        n_checks++; if (count !== 3'd2 || RW !== 5'd22 || PW !== 32'hC2) begin n_fail++; $display("FAIL b2b_2: got count=%0d RW=%0d PW=%h want 2/22/c2", count, RW, PW); end
        @(negedge Clk);
        n_checks++; if (count !== 3'd1 || RW !== 5'd23 || PW !== 32'hC3) begin n_fail++; $display("FAIL b2b_3: got count=%0d RW=%0d PW=%h want 1/23/c3", count, RW, PW); end
        @(negedge Clk);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rf[20 + i] !== 32'hC0 + 32'(i))
                begin n_fail++; $display("FAIL b2b_rf%0d: got %h want %h", 20 + i, rf[20 + i], 32'hC0 + 32'(i)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        Reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wb_hold = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0;
        rd_data_a = '0; rd_data_b = '0; rd_data_c = '0;
        exp_v = '0;
        test_reset();
        test_single();
        test_hold();
        test_r0();
        test_bypass();
        test_wrap_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
